stage_id_ex_pipe: RTL

Registered decode stage for the RV32I core: decodes one instruction per cycle, resolves operands with EX/MEM forwarding, detects load-use hazards, and holds the result in an ID/EX pipeline register with valid/ready handshakes on both sides. It sits between the IF/ID register and the execute stage. It extends the combinational decoder with:
- optional RV32M decode
- operand forwarding
- stall and flush control
- an explicit illegal-instruction flag

---
 rtl/stage_id_ex_pipe.sv | 244 ++++++++++++++++++++++++
 1 files changed

// File: rtl/stage_id_ex_pipe.sv
// ID stage of the RV32I core: decodes one instruction per cycle, resolves
// rs1/rs2 through EX/MEM forwarding, detects load-use hazards and holds the
// decoded instruction in the ID/EX register behind valid/ready handshakes.
module stage_id_ex_pipe #(
  parameter bit RV32M_EN = 1'b1,
  parameter bit FWD_EN   = 1'b1
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_valid,
  output logic        o_ready,
  input  logic [31:0] i_inst,
  input  logic [31:0] i_inst_addr,
  output logic [4:0]  o_reg1_rd_addr,
  output logic [4:0]  o_reg2_rd_addr,
  input  logic [31:0] i_reg1_data,
  input  logic [31:0] i_reg2_data,
  input  logic [31:0] i_ex_result,
  input  logic        i_mem_we,
  input  logic [4:0]  i_mem_wr_addr,
  input  logic [31:0] i_mem_wr_data,
  input  logic        i_ex_jump_flag,
  output logic        o_valid,
  input  logic        i_ready,
  output logic [31:0] o_op1,
  output logic [31:0] o_op2,
  output logic [31:0] o_op1_jump,
  output logic [31:0] o_op2_jump,
  output logic [31:0] o_store_data,
  output logic [31:0] o_inst,
  output logic [31:0] o_inst_addr,
  output logic        o_reg_we,
  output logic [4:0]  o_reg_wr_addr,
  output logic        o_mem_re,
  output logic        o_mem_we,
  output logic        o_muldiv,
  output logic        o_illegal
);

  localparam logic [6:0] OPC_I     = 7'b0010011;
  localparam logic [6:0] OPC_R     = 7'b0110011;
  localparam logic [6:0] OPC_L     = 7'b0000011;
  localparam logic [6:0] OPC_S     = 7'b0100011;
  localparam logic [6:0] OPC_B     = 7'b1100011;
  localparam logic [6:0] OPC_JAL   = 7'b1101111;
  localparam logic [6:0] OPC_JALR  = 7'b1100111;
  localparam logic [6:0] OPC_LUI   = 7'b0110111;
  localparam logic [6:0] OPC_AUIPC = 7'b0010111;

  typedef struct packed {
    logic [31:0] op1, op2, op1_jump, op2_jump, store_data, inst, inst_addr;
    logic        reg_we;
    logic [4:0]  reg_wr_addr;
    logic        mem_re, mem_we, muldiv, illegal;
  } idex_t;

  logic [6:0]  opc, f7;
  logic [2:0]  f3;
  logic [4:0]  rd, rs1, rs2;
  logic [31:0] imm_i, imm_s, imm_b, imm_u, imm_j;
  assign opc   = i_inst[6:0];
  assign rd    = i_inst[11:7];
  assign f3    = i_inst[14:12];
  assign rs1   = i_inst[19:15];
  assign rs2   = i_inst[24:20];
  assign f7    = i_inst[31:25];
  assign imm_i = {{20{i_inst[31]}}, i_inst[31:20]};
  assign imm_s = {{20{i_inst[31]}}, i_inst[31:25], i_inst[11:7]};
  assign imm_b = {{19{i_inst[31]}}, i_inst[31], i_inst[7], i_inst[30:25], i_inst[11:8], 1'b0};
  assign imm_u = {i_inst[31:12], 12'b0};
  assign imm_j = {{11{i_inst[31]}}, i_inst[31], i_inst[19:12], i_inst[20], i_inst[30:21], 1'b0};

  logic        legal, dec_we, dec_re, dec_mwe, dec_md;
  logic [1:0]  use_rs;
  logic [1:0][4:0]  rs_a;
  logic [1:0][31:0] rs_rf, rs_val;
  logic [1:0]  ex_hit, mem_hit;
  logic        ld_use, hazard, advance, accept;
  logic        valid_q;
  idex_t       ex_q, ex_d, ex_bub;

  // Legality, source usage and control bits from opcode/funct fields
  always_comb begin
    legal   = 1'b0;
    use_rs  = 2'b00;
    dec_we  = 1'b0;
    dec_re  = 1'b0;
    dec_mwe = 1'b0;
    dec_md  = 1'b0;
    case (opc)
      OPC_I: begin
        legal  = (f3 == 3'b001) ? (f7 == 7'b0) :
                 (f3 == 3'b101) ? (f7 == 7'b0 || f7 == 7'b0100000) : 1'b1;
        use_rs = 2'b01;
        dec_we = 1'b1;
      end
      OPC_R: begin
        legal  = (f7 == 7'b0) || (f7 == 7'b0100000 && (f3 == 3'b000 || f3 == 3'b101)) ||
                 (RV32M_EN && f7 == 7'b0000001);
        dec_md = RV32M_EN && f7 == 7'b0000001;
        use_rs = 2'b11;
        dec_we = 1'b1;
      end
      OPC_L: begin
        legal  = !(f3 inside {3'b011, 3'b110, 3'b111});
        use_rs = 2'b01;
        dec_we = 1'b1;
        dec_re = 1'b1;
      end
      OPC_S: begin
        legal   = f3 inside {3'b000, 3'b001, 3'b010};
        use_rs  = 2'b11;
        dec_mwe = 1'b1;
      end
      OPC_B: begin
        legal  = !(f3 inside {3'b010, 3'b011});
        use_rs = 2'b11;
      end
      OPC_JAL: begin
        legal  = 1'b1;
        dec_we = 1'b1;
      end
      OPC_JALR: begin
        legal  = (f3 == 3'b000);
        use_rs = 2'b01;
        dec_we = 1'b1;
      end
      OPC_LUI, OPC_AUIPC: begin
        legal  = 1'b1;
        dec_we = 1'b1;
      end
      default: legal = 1'b0;
    endcase
    if (!legal) begin
      use_rs  = 2'b00;
      dec_we  = 1'b0;
      dec_re  = 1'b0;
      dec_mwe = 1'b0;
      dec_md  = 1'b0;
    end
  end

  assign rs_a[0]        = use_rs[0] ? rs1 : 5'd0;
  assign rs_a[1]        = use_rs[1] ? rs2 : 5'd0;
  assign rs_rf[0]       = i_reg1_data;
  assign rs_rf[1]       = i_reg2_data;
  assign o_reg1_rd_addr = rs_a[0];
  assign o_reg2_rd_addr = rs_a[1];

  // Per-source match against EX/MEM destinations and operand forwarding mux
  always_comb begin
    for (int j = 0; j < 2; j++) begin
      ex_hit[j]  = (rs_a[j] != 5'd0) && valid_q && ex_q.reg_we && (ex_q.reg_wr_addr == rs_a[j]);
      mem_hit[j] = (rs_a[j] != 5'd0) && i_mem_we && (i_mem_wr_addr == rs_a[j]);
      if (rs_a[j] == 5'd0)                          rs_val[j] = 32'd0;
      else if (FWD_EN && ex_hit[j] && !ex_q.mem_re) rs_val[j] = i_ex_result;
      else if (FWD_EN && mem_hit[j])                rs_val[j] = i_mem_wr_data;
      else                                          rs_val[j] = rs_rf[j];
    end
  end

  // Without forwarding any pending writer of a source must drain first
  assign ld_use  = FWD_EN ? |(ex_hit & {2{ex_q.mem_re}}) : |(ex_hit | mem_hit);
  assign hazard  = i_valid && ld_use;
  assign advance = i_ready || !valid_q;
  assign o_ready = i_rst && advance && !hazard && !i_ex_jump_flag;
  assign accept  = i_valid && o_ready;

  // Operand/immediate selection into the next ID/EX payload
  always_comb begin
    ex_d             = '0;
    ex_d.inst        = i_inst;
    ex_d.inst_addr   = i_inst_addr;
    ex_d.illegal     = !legal;
    ex_d.reg_we      = dec_we;
    ex_d.reg_wr_addr = dec_we ? rd : 5'd0;
    ex_d.mem_re      = dec_re;
    ex_d.mem_we      = dec_mwe;
    ex_d.muldiv      = dec_md;
    ex_d.store_data  = rs_val[1];
    if (legal) begin
      case (opc)
        OPC_I, OPC_L: begin ex_d.op1 = rs_val[0]; ex_d.op2 = imm_i; end
        OPC_R:        begin ex_d.op1 = rs_val[0]; ex_d.op2 = rs_val[1]; end
        OPC_S:        begin ex_d.op1 = rs_val[0]; ex_d.op2 = imm_s; end
        OPC_B: begin
          ex_d.op1 = rs_val[0]; ex_d.op2 = rs_val[1];
          ex_d.op1_jump = i_inst_addr; ex_d.op2_jump = imm_b;
        end
        OPC_JAL: begin
          ex_d.op1 = i_inst_addr; ex_d.op2 = 32'd4;
          ex_d.op1_jump = i_inst_addr; ex_d.op2_jump = imm_j;
        end
        OPC_JALR: begin
          ex_d.op1 = i_inst_addr; ex_d.op2 = 32'd4;
          ex_d.op1_jump = rs_val[0]; ex_d.op2_jump = imm_i;
        end
        OPC_LUI:   begin ex_d.op1 = imm_u; ex_d.op2 = 32'd0; end
        OPC_AUIPC: begin ex_d.op1 = i_inst_addr; ex_d.op2 = imm_u; end
        default:   ex_d.op1 = 32'd0;
      endcase
    end
  end

  // Bubble keeps the data fields but kills every side-effecting control bit
  always_comb begin
    ex_bub         = ex_q;
    ex_bub.reg_we  = 1'b0;
    ex_bub.mem_re  = 1'b0;
    ex_bub.mem_we  = 1'b0;
    ex_bub.muldiv  = 1'b0;
    ex_bub.illegal = 1'b0;
  end

  // ID/EX register: flush beats everything, then advance, else hold
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      valid_q <= 1'b0;
      ex_q    <= '0;
    end else if (i_ex_jump_flag) begin
      valid_q <= 1'b0;
      ex_q    <= ex_bub;
    end else if (advance) begin
      valid_q <= accept;
      ex_q    <= accept ? ex_d : ex_bub;
    end
  end

  assign o_valid       = valid_q;
  assign o_op1         = ex_q.op1;
  assign o_op2         = ex_q.op2;
  assign o_op1_jump    = ex_q.op1_jump;
  assign o_op2_jump    = ex_q.op2_jump;
  assign o_store_data  = ex_q.store_data;
  assign o_inst        = ex_q.inst;
  assign o_inst_addr   = ex_q.inst_addr;
  assign o_reg_we      = ex_q.reg_we;
  assign o_reg_wr_addr = ex_q.reg_wr_addr;
  assign o_mem_re      = ex_q.mem_re;
  assign o_mem_we      = ex_q.mem_we;
  assign o_muldiv      = ex_q.muldiv;
  assign o_illegal     = ex_q.illegal;

endmodule
